bio_gpio_apb: RTL and testbench
===============================

BIO_GPIO_APB -- requirements
Module: bio_gpio_apb

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- AW, 13, APB address width.
- NGPIO, 32, pin count, 1..32.
- NIRQ, 4, interrupt line count, 1..8.
- SYNC_STAGES, 2, input synchroniser depth, 2..3.

REQ-002 SHALL have ports (name, direction, width, meaning):
- pclk, in, 1, the only clock.
- resetn, in, 1, asynchronous active-low reset.
- PSEL, in, 1, APB select.
- PENABLE, in, 1, APB enable.
- PWRITE, in, 1, APB write.
- PADDR, in, AW, APB byte address.
- PSTRB, in, 4, APB write byte strobes.
- PPROT, in, 3, APB protection; ignored.
- PWDATA, in, 32, APB write data.
- PRDATA, out, 32, APB read data.
- PREADY, out, 1, APB ready.
- PSLVERR, out, 1, APB error.
- gpio_in, in, NGPIO, asynchronous pad inputs.
- gpio_out, out, NGPIO, pad output values.
- gpio_dir, out, NGPIO, pad output enables; 1 = drive.
- irq, out, NIRQ, level interrupts.

Function
REQ-003 SHALL tie PREADY to 1; an access completes in the cycle where PSEL, PENABLE and PREADY are all 1.
REQ-004 SHALL decode PADDR[AW-1:2] as a word index. Register map:
- 0x00 OUT, RW.
- 0x04 DIR, RW.
- 0x08 IN, RO.
- 0x0C SET, WO: ORs write data into OUT.
- 0x10 CLR, WO: clears OUT bits set in write data.
- 0x14 RISE_EN, RW.
- 0x18 FALL_EN, RW.
- 0x1C PENDING, write-1-to-clear.
- 0x20+4k MASK[k], RW, for k < NIRQ.
REQ-005 SHALL apply every write per byte lane under PSTRB; a lane with PSTRB=0 leaves its bits unchanged.
REQ-006 SHALL read bits at and above NGPIO as 0 and ignore writes to them.
REQ-007 SHALL read WO registers as 0.
REQ-008 SHALL assert PSLVERR in the access phase for an unmapped address or a write to IN. Such an access SHALL change no state and SHALL return PRDATA=0.
REQ-009 SHALL drive PRDATA combinationally from the decoded register during the access phase, and 0 otherwise.
REQ-010 SHALL pass each gpio_in bit through SYNC_STAGES flops. IN SHALL reflect a pin change exactly SYNC_STAGES cycles after it is sampled.
REQ-011 SHALL keep a one-cycle-delayed copy of the synchronised input. Edge detection:
- Rising edge: previous=0, current=1, RISE_EN bit=1.
- Falling edge: previous=1, current=0, FALL_EN bit=1.
- A detected edge sets its PENDING bit in the next cycle.
REQ-012 SHALL give edge-set priority over W1C when both hit the same PENDING bit in the same cycle; the bit stays 1.
REQ-013 SHALL register irq[k] = OR of (PENDING & MASK[k]), one cycle after PENDING or MASK changes.
REQ-014 SHALL make a same-cycle SET and CLR impossible, since APB is single-access; back-to-back SET then CLR SHALL each take effect in their own access cycle.
REQ-015 SHALL never set PENDING when RISE_EN or FALL_EN is enabled over a pin that is already at a level; only transitions count.

Reset
REQ-016 SHALL, on resetn low and independent of pclk, clear to 0:
- OUT, DIR, RISE_EN, FALL_EN, PENDING, all MASK registers.
- Synchroniser flops and the delayed copy.
- irq, gpio_out, gpio_dir.
REQ-017 SHALL treat reset assertion mid-access as aborting the access, with no residual state.
REQ-018 SHALL deassert reset without generating spurious PENDING bits, because the enables are 0 out of reset.

Configuration
REQ-019 SHALL, with BIO_GPIO_DEBOUNCE_EN defined, add:
- A DEBOUNCE register at 0x40 (RW, bits 7:0, reset 0).
- A per-pin filter that changes its output only after the synchronised input has differed from it for DEBOUNCE+1 consecutive cycles.
- The filter output feeds IN and edge detection; a glitch shorter than that window causes no change and no PENDING.
REQ-020 SHALL, without BIO_GPIO_DEBOUNCE_EN, omit the filter and treat 0x40 as unmapped (PSLVERR).

Structure
REQ-021 SHALL place register offsets, the word-index enum and MAX_NGPIO=32 in package bio_gpio_pkg.
REQ-022 SHALL implement synchroniser, optional debounce and edge detect as sub-module bio_gpio_inpipe, instantiated once per pin in a generate loop.

Verification
REQ-023 Write OUT=0x0000_00FF with PSTRB=4'b0001, then SET 0x0100, then CLR 0x0001 -> OUT reads 0x0000_01FE; PSLVERR=0 on all three.
REQ-024 RISE_EN=0x1, MASK[0]=0x1, drive gpio_in[0] 0->1 -> PENDING[0]=1 at cycle SYNC_STAGES+1 and irq[0]=1 one cycle later; W1C 0x1 -> irq[0]=0 one cycle later.
REQ-025 Falling edge on pin 3 in the same cycle as a W1C of bit 3 -> PENDING[3] remains 1.
REQ-026 Read 0x3C and write 0x08 -> PSLVERR=1, PRDATA=0, IN unchanged.
REQ-027 With BIO_GPIO_DEBOUNCE_EN and DEBOUNCE=3: a 3-cycle pulse on pin 1 gives no PENDING; a 4-cycle pulse sets PENDING[1] with RISE_EN=0x2.
REQ-028 Assert resetn low mid-write to OUT -> gpio_out=0 and irq=0 immediately; after release OUT reads 0.

Source files
------------

// File: rtl/bio_gpio_pkg.sv
// bio_gpio_pkg -- shared definitions for the APB GPIO block.
//   Register byte offsets, the word-index enum used by the address decoder,
//   the architectural pin limit and a byte-strobe expansion helper.
//   Optional feature macro: BIO_GPIO_DEBOUNCE_EN (adds the DEBOUNCE register).
package bio_gpio_pkg;

    localparam int MAX_NGPIO = 32;

    localparam logic [7:0] OFF_OUT      = 8'h00;
    localparam logic [7:0] OFF_DIR      = 8'h04;
    localparam logic [7:0] OFF_IN       = 8'h08;
    localparam logic [7:0] OFF_SET      = 8'h0C;
    localparam logic [7:0] OFF_CLR      = 8'h10;
    localparam logic [7:0] OFF_RISE_EN  = 8'h14;
    localparam logic [7:0] OFF_FALL_EN  = 8'h18;
    localparam logic [7:0] OFF_PENDING  = 8'h1C;
    localparam logic [7:0] OFF_MASK0    = 8'h20;
    localparam logic [7:0] OFF_DEBOUNCE = 8'h40;

    // Word index = byte offset >> 2; only the low 5 bits are decoded, the
    // rest of the index must be zero.
    typedef enum logic [4:0] {
        W_OUT   = 5'd0,  W_DIR   = 5'd1,  W_IN    = 5'd2,  W_SET   = 5'd3,
        W_CLR   = 5'd4,  W_RISE  = 5'd5,  W_FALL  = 5'd6,  W_PEND  = 5'd7,
        W_MASK0 = 5'd8,  W_MASK1 = 5'd9,  W_MASK2 = 5'd10, W_MASK3 = 5'd11,
        W_MASK4 = 5'd12, W_MASK5 = 5'd13, W_MASK6 = 5'd14, W_MASK7 = 5'd15,
        W_DEB   = 5'd16
    } widx_e;

    // Expand the 4-bit APB strobe into a 32-bit bit mask.
    function automatic logic [31:0] byte_mask(input logic [3:0] strb);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{strb[i]}};
        return m;
    endfunction

endpackage

// File: rtl/bio_gpio_inpipe.sv
// bio_gpio_inpipe -- per-pin input path: synchroniser, optional debounce
// filter (BIO_GPIO_DEBOUNCE_EN) and edge detector.
//   pclk, resetn       : clock, async active-low reset
//   pin                : raw asynchronous pad input
//   rise_en, fall_en   : edge enables for this pin
//   deb                : debounce window (only with BIO_GPIO_DEBOUNCE_EN)
//   lvl                : clean level (feeds the IN register)
//   hit                : enabled edge seen this cycle (sets PENDING next edge)
module bio_gpio_inpipe #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       pclk,
    input  logic       resetn,
    input  logic       pin,
    input  logic       rise_en,
    input  logic       fall_en,
`ifdef BIO_GPIO_DEBOUNCE_EN
    input  logic [7:0] deb,
`endif
    output logic       lvl,
    output logic       hit
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   cur;
    logic                   prev;

    always_ff @(posedge pclk or negedge resetn) begin
        if (!resetn) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pin};
            prev <= cur;
        end
    end

`ifdef BIO_GPIO_DEBOUNCE_EN
    // Output follows the synchronised input only after it has disagreed for
    // deb+1 consecutive cycles; any agreement restarts the count.
    logic       filt;
    logic [7:0] cnt;

    always_ff @(posedge pclk or negedge resetn) begin
        if (!resetn) begin
            filt <= 1'b0;
            cnt  <= '0;
        end else if (sync[SYNC_STAGES-1] == filt) begin
            cnt <= '0;
        end else if (cnt == deb) begin
            filt <= sync[SYNC_STAGES-1];
            cnt  <= '0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

    assign cur = filt;
`else
    assign cur = sync[SYNC_STAGES-1];
`endif

    assign lvl = cur;
    // Only transitions count; an enable raised over a steady level is silent.
    assign hit = (rise_en & cur & ~prev) | (fall_en & ~cur & prev);

endmodule

// File: rtl/bio_gpio_apb.sv
// bio_gpio_apb -- APB3/4 GPIO controller with edge-triggered, maskable
// level interrupts. Optional BIO_GPIO_DEBOUNCE_EN adds a per-pin glitch
// filter and the DEBOUNCE register at 0x40 (unmapped otherwise).
//   pclk, resetn                 : clock, async active-low reset
//   PSEL..PWDATA, PPROT          : APB request (PPROT ignored)
//   PRDATA, PREADY, PSLVERR      : APB response (zero wait states)
//   gpio_in                      : asynchronous pad inputs
//   gpio_out, gpio_dir           : pad output values / output enables
//   irq                          : registered level interrupts
module bio_gpio_apb #(
    parameter int AW          = 13,
    parameter int NGPIO       = 32,
    parameter int NIRQ        = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             pclk,
    input  logic             resetn,
    input  logic             PSEL,
    input  logic             PENABLE,
    input  logic             PWRITE,
    input  logic [AW-1:0]    PADDR,
    input  logic [3:0]       PSTRB,
    input  logic [2:0]       PPROT,
    input  logic [31:0]      PWDATA,
    output logic [31:0]      PRDATA,
    output logic             PREADY,
    output logic             PSLVERR,
    input  logic [NGPIO-1:0] gpio_in,
    output logic [NGPIO-1:0] gpio_out,
    output logic [NGPIO-1:0] gpio_dir,
    output logic [NIRQ-1:0]  irq
);
    import bio_gpio_pkg::*;

    localparam int WIW = AW - 2;

    logic [NGPIO-1:0] out_r, dir_r, rise_r, fall_r, pend_r;
    logic [NGPIO-1:0] mask_r [NIRQ];
    logic [NIRQ-1:0]  irq_r;
    logic [NGPIO-1:0] lvl, hit, wval, bm_n, w1c;
`ifdef BIO_GPIO_DEBOUNCE_EN
    logic [7:0]       deb_r;
`endif

    logic [WIW-1:0] widx;
    widx_e          wsel;
    logic [2:0]     mk;
    logic           in_range, mask_hit, mapped, err, acc, wr;
    logic [31:0]    rd, bmask;
    logic           unused_ok;

    assign unused_ok = ^{PPROT, PADDR[1:0]};

    assign widx     = PADDR[AW-1:2];
    assign in_range = (widx >> 5) == '0;
    assign wsel     = widx_e'(widx[4:0]);
    assign mk       = widx[2:0];
    assign mask_hit = in_range && (widx[4:3] == 2'b01) && (int'(mk) < NIRQ);

    assign acc   = PSEL & PENABLE;
    assign bmask = byte_mask(PSTRB);
    assign wval  = NGPIO'(PWDATA & bmask);
    assign bm_n  = ~NGPIO'(bmask);

    always_comb begin
        mapped = in_range;
        rd     = '0;
        case (wsel)
            W_OUT:        rd = 32'(out_r);
            W_DIR:        rd = 32'(dir_r);
            W_IN:         rd = 32'(lvl);
            W_SET, W_CLR: rd = '0;
            W_RISE:       rd = 32'(rise_r);
            W_FALL:       rd = 32'(fall_r);
            W_PEND:       rd = 32'(pend_r);
`ifdef BIO_GPIO_DEBOUNCE_EN
            W_DEB:        rd = {24'd0, deb_r};
`endif
            default: begin
                mapped = mask_hit;
                for (int k = 0; k < NIRQ; k++)
                    if (mask_hit && int'(mk) == k) rd = 32'(mask_r[k]);
            end
        endcase
    end

    // Errored accesses neither return data nor touch state.
    assign err     = ~mapped | (PWRITE & (wsel == W_IN));
    assign wr      = acc & PWRITE & ~err;
    assign PREADY  = 1'b1;
    assign PSLVERR = acc & err;
    assign PRDATA  = (acc && !err) ? rd : '0;

    assign w1c = (wr && wsel == W_PEND) ? wval : '0;

    always_ff @(posedge pclk or negedge resetn) begin
        if (!resetn) begin
            out_r  <= '0;
            dir_r  <= '0;
            rise_r <= '0;
            fall_r <= '0;
            pend_r <= '0;
            irq_r  <= '0;
            for (int k = 0; k < NIRQ; k++) mask_r[k] <= '0;
`ifdef BIO_GPIO_DEBOUNCE_EN
            deb_r  <= '0;
`endif
        end else begin
            // Edge set wins over a same-cycle W1C.
            pend_r <= (pend_r & ~w1c) | hit;
            for (int k = 0; k < NIRQ; k++) irq_r[k] <= |(pend_r & mask_r[k]);
            if (wr) begin
                case (wsel)
                    W_OUT:  out_r  <= (out_r  & bm_n) | wval;
                    W_DIR:  dir_r  <= (dir_r  & bm_n) | wval;
                    W_SET:  out_r  <= out_r | wval;
                    W_CLR:  out_r  <= out_r & ~wval;
                    W_RISE: rise_r <= (rise_r & bm_n) | wval;
                    W_FALL: fall_r <= (fall_r & bm_n) | wval;
`ifdef BIO_GPIO_DEBOUNCE_EN
                    W_DEB:  deb_r  <= (deb_r & ~bmask[7:0]) | (PWDATA[7:0] & bmask[7:0]);
`endif
                    default: begin
                        for (int k = 0; k < NIRQ; k++)
                            if (mask_hit && int'(mk) == k)
                                mask_r[k] <= (mask_r[k] & bm_n) | wval;
                    end
                endcase
            end
        end
    end

    for (genvar i = 0; i < NGPIO; i++) begin : g_pin
        bio_gpio_inpipe #(.SYNC_STAGES(SYNC_STAGES)) u_pin (
            .pclk    (pclk),
            .resetn  (resetn),
            .pin     (gpio_in[i]),
            .rise_en (rise_r[i]),
            .fall_en (fall_r[i]),
`ifdef BIO_GPIO_DEBOUNCE_EN
            .deb     (deb_r),
`endif
            .lvl     (lvl[i]),
            .hit     (hit[i])
        );
    end

    assign gpio_out = out_r;
    assign gpio_dir = dir_r;
    assign irq      = irq_r;

endmodule

// File: tb/tb_bio_gpio_apb.sv
// tb_bio_gpio_apb -- self-checking bench for bio_gpio_apb (NGPIO=24 so that
// unimplemented upper bits are exercised). Table of APB vectors, hand-timed
// edge/irq/reset sequences, then random traffic against a register model.
`timescale 1ns/1ps
module tb_bio_gpio_apb;

    localparam int AW = 13, NGPIO = 24, NIRQ = 4, SS = 2;
`ifdef BIO_GPIO_DEBOUNCE_EN
    localparam int   LAT     = SS + 1;
    localparam logic DEB_ERR = 1'b0;
`else
    localparam int   LAT     = SS;
    localparam logic DEB_ERR = 1'b1;
`endif
    localparam logic [31:0] PM = 32'h00FF_FFFF;

    logic             pclk = 1'b0, resetn = 1'b0;
    logic             PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [AW-1:0]    PADDR = '0;
    logic [3:0]       PSTRB = '0;
    logic [2:0]       PPROT = '0;
    logic [31:0]      PWDATA = '0, PRDATA;
    logic             PREADY, PSLVERR;
    logic [NGPIO-1:0] gpio_in = '0, gpio_out, gpio_dir;
    logic [NIRQ-1:0]  irq;

    int nvec = 0, nerr = 0;

    bio_gpio_apb #(.AW(AW), .NGPIO(NGPIO), .NIRQ(NIRQ), .SYNC_STAGES(SS)) dut (
        .pclk(pclk), .resetn(resetn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PSTRB(PSTRB), .PPROT(PPROT), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .gpio_in(gpio_in), .gpio_out(gpio_out),
        .gpio_dir(gpio_dir), .irq(irq)
    );

    always #5 pclk = ~pclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge pclk); #1; end
    endtask

    // Called 1 time unit after a rising edge; returns at the same phase.
    task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, output logic [31:0] rdata, output logic err);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr[AW-1:0];
        PWDATA = data; PSTRB = strb; PPROT = 3'b010;
        @(posedge pclk); #1 PENABLE = 1'b1;
        #3;
        rdata = PRDATA; err = PSLVERR;
        @(posedge pclk); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic wr32(input string name, input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] r; logic e;
        apb(1'b1, addr, data, 4'hF, r, e);
        check({name, "_err"}, 32'(e), 32'd0);
    endtask

    task automatic rd32(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] r; logic e;
        apb(1'b0, addr, 32'd0, 4'h0, r, e);
        check(name, r, exp);
    endtask

    function automatic logic [31:0] lanes(input logic [3:0] strb);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = strb[i] ? 8'hFF : 8'h00;
        return m;
    endfunction

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
        logic        eerr;
    } vec_t;

    vec_t tbl[$];

    // register model for the random phase
    logic [31:0] m_out, m_dir, m_rise, m_fall, m_pend, m_pin;
    logic [31:0] m_mask [NIRQ];

    initial begin
        logic [31:0] r, d, bm, a, exp_rd;
        logic e, w, exp_err;
        logic [3:0] s;
        logic [NIRQ-1:0] exp_irq;
        logic [31:0] addrs [16];

        tbl.push_back('{1'b0, 32'h00, 32'h0,        4'h0, 32'h0,        1'b0});
        tbl.push_back('{1'b0, 32'h04, 32'h0,        4'h0, 32'h0,        1'b0});
        tbl.push_back('{1'b0, 32'h1C, 32'h0,        4'h0, 32'h0,        1'b0});
        tbl.push_back('{1'b0, 32'h08, 32'h0,        4'h0, 32'h005A0F3C, 1'b0});
        tbl.push_back('{1'b1, 32'h00, 32'h000000FF, 4'h1, 32'h0,        1'b0});
        tbl.push_back('{1'b1, 32'h0C, 32'h00000100, 4'hF, 32'h0,        1'b0});
        tbl.push_back('{1'b1, 32'h10, 32'h00000001, 4'hF, 32'h0,        1'b0});
        tbl.push_back('{1'b0, 32'h00, 32'h0,        4'h0, 32'h000001FE, 1'b0});
        tbl.push_back('{1'b0, 32'h0C, 32'h0,        4'h0, 32'h0,        1'b0});
        tbl.push_back('{1'b0, 32'h10, 32'h0,        4'h0, 32'h0,        1'b0});
        tbl.push_back('{1'b0, 32'h3C, 32'h0,        4'h0, 32'h0,        1'b1});
        tbl.push_back('{1'b1, 32'h08, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1});
        tbl.push_back('{1'b0, 32'h08, 32'h0,        4'h0, 32'h005A0F3C, 1'b0});
        tbl.push_back('{1'b1, 32'h00, 32'hAABBCCDD, 4'hA, 32'h0,        1'b0});
        tbl.push_back('{1'b0, 32'h00, 32'h0,        4'h0, 32'h0000CCFE, 1'b0});
        tbl.push_back('{1'b1, 32'h04, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b0});
        tbl.push_back('{1'b0, 32'h04, 32'h0,        4'h0, 32'h00FFFFFF, 1'b0});
        tbl.push_back('{1'b1, 32'h2C, 32'h12345678, 4'h7, 32'h0,        1'b0});
        tbl.push_back('{1'b0, 32'h2C, 32'h0,        4'h0, 32'h00345678, 1'b0});
        tbl.push_back('{1'b0, 32'h30, 32'h0,        4'h0, 32'h0,        1'b1});
        tbl.push_back('{1'b0, 32'h40, 32'h0,        4'h0, 32'h0,        DEB_ERR});
        tbl.push_back('{1'b1, 32'h00, 32'h0,        4'hF, 32'h0,        1'b0});
        tbl.push_back('{1'b1, 32'h04, 32'h0,        4'hF, 32'h0,        1'b0});
        tbl.push_back('{1'b1, 32'h2C, 32'h0,        4'hF, 32'h0,        1'b0});
        tbl.push_back('{1'b0, 32'h00, 32'h0,        4'h0, 32'h0,        1'b0});

        // ---- reset state
        gpio_in = 24'h5A0F3C;
        tick(3);
        check("rst_gpio_out", 32'(gpio_out), 32'd0);
        check("rst_gpio_dir", 32'(gpio_dir), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("idle_prdata", PRDATA, 32'd0);
        check("pready", 32'(PREADY), 32'd1);
        resetn = 1'b1;
        tick(LAT + 3);

        // ---- table vectors
        foreach (tbl[i]) begin
            apb(tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].strb, r, e);
            if (!tbl[i].wr || tbl[i].eerr)
                check($sformatf("tbl%0d_rdata", i), r, tbl[i].exp);
            check($sformatf("tbl%0d_slverr", i), 32'(e), 32'(tbl[i].eerr));
        end

        // ---- rising edge on pin 0 -> PENDING -> irq, then W1C
        wr32("rise_en", 32'h14, 32'h1);
        wr32("mask0", 32'h20, 32'h1);
        gpio_in[0] = 1'b1;
        tick(LAT + 1);
        check("irq0_before", 32'(irq[0]), 32'd0);
        tick(1);
        check("irq0_after", 32'(irq[0]), 32'd1);
        rd32("pend_rise", 32'h1C, 32'h1);
        wr32("w1c0", 32'h1C, 32'h1);
        check("irq0_hold", 32'(irq[0]), 32'd1);
        tick(1);
        check("irq0_clear", 32'(irq[0]), 32'd0);
        rd32("pend_cleared", 32'h1C, 32'h0);

        // ---- falling edge on pin 3 lands on the same edge as a W1C of bit 3
        wr32("fall_en", 32'h18, 32'h8);
        gpio_in[3] = 1'b0;
        tick(LAT + 3);
        rd32("pend_fall", 32'h1C, 32'h8);
        gpio_in[3] = 1'b1;
        tick(LAT + 3);
        gpio_in[3] = 1'b0;
        tick(LAT - 1);
        wr32("w1c3_race", 32'h1C, 32'h8);
        rd32("pend_race", 32'h1C, 32'h8);
        wr32("w1c3", 32'h1C, 32'h8);
        rd32("pend_race_clr", 32'h1C, 32'h0);

`ifdef BIO_GPIO_DEBOUNCE_EN
        // ---- debounce window of 4 cycles
        wr32("deb", 32'h40, 32'h3);
        rd32("deb_rd", 32'h40, 32'h3);
        wr32("rise_en1", 32'h14, 32'h2);
        gpio_in[1] = 1'b1; tick(3); gpio_in[1] = 1'b0; tick(12);
        rd32("deb_short", 32'h1C, 32'h0);
        gpio_in[1] = 1'b1; tick(4); gpio_in[1] = 1'b0; tick(12);
        rd32("deb_long", 32'h1C, 32'h2);
`endif

        // ---- reset in the middle of a write to OUT
        wr32("rise_en0", 32'h14, 32'h1);
        wr32("out55", 32'h00, 32'h55);
        gpio_in[0] = 1'b0; tick(LAT + 3);
        gpio_in[0] = 1'b1; tick(LAT + 4);
        check("pre_rst_irq", 32'(irq[0]), 32'd1);
        check("pre_rst_out", 32'(gpio_out), 32'h55);
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = '0; PWDATA = 32'hAA; PSTRB = 4'hF;
        @(posedge pclk); #1 PENABLE = 1'b1;
        #2 resetn = 1'b0;
        #1;
        check("midrst_gpio_out", 32'(gpio_out), 32'd0);
        check("midrst_irq", 32'(irq), 32'd0);
        @(posedge pclk); #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        tick(2);
        resetn = 1'b1;
        tick(LAT + 4);
        rd32("post_rst_out", 32'h00, 32'h0);
        rd32("post_rst_pend", 32'h1C, 32'h0);
        rd32("post_rst_mask0", 32'h20, 32'h0);
        rd32("post_rst_in", 32'h08, 32'(gpio_in));

        // ---- random traffic against the model
        m_out = '0; m_dir = '0; m_rise = '0; m_fall = '0; m_pend = '0;
        m_pin = 32'(gpio_in);
        for (int k = 0; k < NIRQ; k++) m_mask[k] = '0;
        addrs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C,
                  32'h20, 32'h24, 32'h28, 32'h2C, 32'h30, 32'h3C, 32'h44, 32'h1000};

        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 9) < 2) begin
                d = $urandom & PM;
                m_pend |= ((~m_pin & d & m_rise) | (m_pin & ~d & m_fall)) & PM;
                m_pin = d;
                gpio_in = d[NGPIO-1:0];
                tick(LAT + 3);
                for (int k = 0; k < NIRQ; k++) exp_irq[k] = |(m_pend & m_mask[k]);
                check($sformatf("rnd%0d_irq", it), 32'(irq), 32'(exp_irq));
            end else begin
                a = addrs[$urandom_range(0, 15)];
                w = 1'($urandom_range(0, 1));
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                bm = lanes(s) & PM;
                exp_err = 1'b0;
                exp_rd  = '0;
                case (a)
                    32'h00: exp_rd = m_out;
                    32'h04: exp_rd = m_dir;
                    32'h08: begin exp_rd = m_pin; exp_err = w; end
                    32'h0C, 32'h10: exp_rd = '0;
                    32'h14: exp_rd = m_rise;
                    32'h18: exp_rd = m_fall;
                    32'h1C: exp_rd = m_pend;
                    32'h20, 32'h24, 32'h28, 32'h2C: exp_rd = m_mask[(a - 32'h20) >> 2];
                    default: exp_err = 1'b1;
                endcase
                if (exp_err) exp_rd = '0;
                apb(w, a, d, s, r, e);
                check($sformatf("rnd%0d_err_a%0h", it, a), 32'(e), 32'(exp_err));
                if (!w) check($sformatf("rnd%0d_rd_a%0h", it, a), r, exp_rd);
                if (w && !exp_err) begin
                    case (a)
                        32'h00: m_out  = (m_out  & ~bm) | (d & bm);
                        32'h04: m_dir  = (m_dir  & ~bm) | (d & bm);
                        32'h0C: m_out  = m_out | (d & bm);
                        32'h10: m_out  = m_out & ~(d & bm);
                        32'h14: m_rise = (m_rise & ~bm) | (d & bm);
                        32'h18: m_fall = (m_fall & ~bm) | (d & bm);
                        32'h1C: m_pend = m_pend & ~(d & bm);
                        default: m_mask[(a - 32'h20) >> 2] = (m_mask[(a - 32'h20) >> 2] & ~bm) | (d & bm);
                    endcase
                end
                check($sformatf("rnd%0d_gpio_out", it), 32'(gpio_out), m_out);
                check($sformatf("rnd%0d_gpio_dir", it), 32'(gpio_dir), m_dir);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
